// File: rtl/dequant_shift_pkg.sv
// dequant_shift_pkg: shared FSM encoding and default widths for the dequantizer
package dequant_shift_pkg;

   localparam int DW_DEF = 8;
   localparam int AW_DEF = 64;
   localparam int LW_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/dequant_shift_sat_shl.sv
// sat_shl: combinational signed left shift that clamps to the AW-bit range
module sat_shl
   import dequant_shift_pkg::*;
#(
   parameter int AW = AW_DEF
)(
   input  logic [AW-1:0] x,
   input  logic [7:0]    shift,
   output logic [AW-1:0] y,
   output logic          sat
);

   logic [AW-1:0] shl;
   logic          ovf;

   // Overflow is detected by shifting back arithmetically; a zero input never overflows
   always_comb begin
      shl = x << shift;
      ovf = (int'(shift) >= AW) || (($signed(shl) >>> shift) != $signed(x));
      sat = (x != '0) && ovf;
      y   = !sat ? shl : x[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
   end

endmodule

// File: rtl/dequant_shift.sv
// dequant_shift: framed dequantizer, sign-extend then shift-and-saturate in two stages
module dequant_shift
   import dequant_shift_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF,
   parameter int LW = LW_DEF
)(
   input  logic          CLK,
   input  logic          RST,
   input  logic          CFG_WE,
   input  logic [7:0]    CFG_SHIFT,
   input  logic [LW-1:0] CFG_LEN,
   input  logic          IN_VALID,
   output logic          IN_READY,
   input  logic [DW-1:0] IN_DATA,
   output logic          OUT_VALID,
   input  logic          OUT_READY,
   output logic [AW-1:0] OUT_DATA,
   output logic          OUT_LAST,
   output logic          OUT_SAT,
   output logic [LW-1:0] SAT_CNT,
   output logic          BUSY
);

   state_t        state;
   logic [LW-1:0] cnt;
   logic [LW-1:0] len_r;
   logic [7:0]    shift_r;
   logic          s1_v;
   logic          s1_last;
   logic [AW-1:0] s1_x;
   logic [AW-1:0] s2_y;
   logic          s2_sat;
   logic          stall;
   logic          in_xfer;
   logic          out_xfer;
   logic          last_in;
   logic          cfg_ok;

   // len_r of 0 wraps to all-ones here, which gives the 2^LW frame length
   assign stall    = OUT_VALID & ~OUT_READY;
   assign IN_READY = ~stall & (state != DRAIN);
   assign in_xfer  = IN_VALID & IN_READY;
   assign out_xfer = OUT_VALID & OUT_READY;
   assign last_in  = cnt == len_r - LW'(1);
   assign cfg_ok   = (state == IDLE) & CFG_WE & ~in_xfer;
   assign BUSY     = state != IDLE;

   sat_shl #(.AW(AW)) u_sat_shl (
      .x     (s1_x),
      .shift (shift_r),
      .y     (s2_y),
      .sat   (s2_sat)
   );

   // Frame control: accepted-element count, config latch and saturation counter
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         cnt     <= '0;
         shift_r <= '0;
         len_r   <= LW'(1);
         SAT_CNT <= '0;
      end else begin
         if (in_xfer) cnt <= cnt + LW'(1);
         if (cfg_ok) begin
            shift_r <= CFG_SHIFT;
            len_r   <= CFG_LEN;
         end
         case (state)
            IDLE:    if (in_xfer) state <= last_in ? DRAIN : RUN;
            RUN:     if (in_xfer && last_in) state <= DRAIN;
            DRAIN:   if (out_xfer && OUT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                     end
            default: state <= IDLE;
         endcase
         if (cfg_ok) SAT_CNT <= '0;
         else if (out_xfer && OUT_SAT && SAT_CNT != '1) SAT_CNT <= SAT_CNT + LW'(1);
      end
   end

   // Two-stage datapath that freezes as a whole while the output is back-pressured
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1_v      <= 1'b0;
         s1_x      <= '0;
         s1_last   <= 1'b0;
         OUT_VALID <= 1'b0;
         OUT_DATA  <= '0;
         OUT_LAST  <= 1'b0;
         OUT_SAT   <= 1'b0;
      end else if (!stall) begin
         s1_v      <= in_xfer;
         s1_x      <= in_xfer ? {{(AW-DW){IN_DATA[DW-1]}}, IN_DATA} : '0;
         s1_last   <= in_xfer & last_in;
         OUT_VALID <= s1_v;
         OUT_DATA  <= s1_v ? s2_y : '0;
         OUT_LAST  <= s1_v & s1_last;
         OUT_SAT   <= s1_v & s2_sat;
      end
   end

endmodule

// File: doc/dequant_shift.md
DEQUANT_SHIFT -- requirements
Module: dequant_shift

Interface
REQ-001 Parameter DW, default 8, SHALL set the quantized input width in bits (signed two's complement).
REQ-002 Parameter AW, default 64, SHALL set the accumulator-domain output width in bits (signed).
REQ-003 Parameter LW, default 16, SHALL set the frame-length and saturation-counter width.
REQ-004 CLK  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 RST  in  1  SHALL be an asynchronous, active-high reset.
REQ-006 CFG_WE  in  1  SHALL be the configuration write strobe.
REQ-007 CFG_SHIFT  in  8  SHALL give the left-shift amount, 0..255.
REQ-008 CFG_LEN  in  LW  SHALL give the elements per frame; 0 SHALL mean 2^LW.
REQ-009 IN_VALID / IN_READY  in / out  1 / 1  SHALL form the input handshake; a transfer occurs when both are high.
REQ-010 IN_DATA  in  DW  SHALL carry the signed quantized element.
REQ-011 OUT_VALID / OUT_READY  out / in  1 / 1  SHALL form the output handshake.
REQ-012 OUT_DATA  out  AW  SHALL carry the dequantized value.
REQ-013 OUT_LAST  out  1  SHALL mark the final element of a frame.
REQ-014 OUT_SAT  out  1  SHALL flag that the current OUT_DATA was saturated.
REQ-015 SAT_CNT  out  LW  SHALL count saturated outputs and stick at its maximum value.
REQ-016 BUSY  out  1  SHALL be high whenever the state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, RUN and DRAIN.
REQ-018 IDLE -> RUN on an input transfer when the effective length is greater than 1; IDLE -> DRAIN on an input transfer when the effective length is 1.
REQ-019 RUN -> DRAIN on the input transfer that brings the accepted count to the effective length.
REQ-020 DRAIN -> IDLE on the output transfer that has OUT_LAST=1.
REQ-021 CFG_WE SHALL latch CFG_SHIFT and CFG_LEN and clear SAT_CNT only in IDLE, and only when no input transfer occurs in the same cycle; otherwise CFG_WE SHALL be ignored.
REQ-022 Datapath SHALL be two register stages:
- S1 registers the sign-extended input plus its last tag.
- S2 registers the shifted/saturated result, last and sat flags.
REQ-023 Without stall, OUT_VALID SHALL rise exactly 2 cycles after the input transfer.
REQ-024 Stall = OUT_VALID & !OUT_READY; during stall S1 and S2 SHALL hold and OUT_* SHALL remain stable.
REQ-025 IN_READY SHALL equal !stall & (state != DRAIN).
REQ-026 Result SHALL equal sext(IN_DATA) * 2^shift when that value fits in a signed AW-bit value.
REQ-027 Otherwise the result SHALL saturate to 2^(AW-1)-1 for positive inputs or -2^(AW-1) for negative inputs, with OUT_SAT=1.
REQ-028 Shift >= AW with a nonzero input SHALL saturate; an input of 0 SHALL never saturate, for any shift.
REQ-029 SAT_CNT SHALL increment once per output transfer with OUT_SAT=1 and SHALL hold at 2^LW-1.
REQ-030 The accepted-element counter SHALL clear on entry to IDLE.

Reset
REQ-031 RST SHALL force state IDLE and clear all counters, pipeline valid bits, OUT_DATA, OUT_LAST, OUT_SAT, OUT_VALID, SAT_CNT and BUSY to 0.
REQ-032 Reset values SHALL be shift register = 0 and length register = 1.
REQ-033 RST asserted mid-frame SHALL discard in-flight data; no output SHALL appear after release.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding and the DW/AW/LW defaults.
REQ-035 One sub-module, sat_shl, SHALL implement the combinational shift-and-saturate used by S2.

Verification
REQ-036 Shift 4, len 3, inputs 0x01, 0xFF, 0x7F -> outputs 0x10, 0xFFFF_FFFF_FFFF_FFF0, 0x7F0; OUT_LAST on the third output; each output 2 cycles after its input.
REQ-037 Shift 56, input 0x80 -> 0x8000_0000_0000_0000 with OUT_SAT=0; shift 57, input 0x80 -> 0x8000_0000_0000_0000 with OUT_SAT=1; shift 57, input 0x7F -> 0x7FFF_FFFF_FFFF_FFFF with OUT_SAT=1; SAT_CNT=2.
REQ-038 Shift 200, input 0x00 -> output 0 with OUT_SAT=0; shift 200, input 0x01 -> saturated maximum.
REQ-039 OUT_READY held low 5 cycles mid-frame -> OUT_DATA stable, IN_READY low throughout the stall, no element lost or duplicated.
REQ-040 CFG_WE with shift 9 during RUN -> ignored, frame completes with the old shift; CFG_WE in IDLE -> applied to the next frame.
REQ-041 RST pulse during RUN after 2 accepted elements -> all outputs 0, BUSY=0, no OUT_VALID until new input.
